// File: rtl/sqr_result_gather.sv
// Gathers squarer result words alternately from banks C and D and writes each into bank A as two 128-bit halves.
// Four cycles per word (RD, WAIT, WLO, WHI) plus one DONE cycle; commands are ignored while a gather runs.
module sqr_result_gather #(
  parameter int ADDR = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      command,
  input  logic [ADDR-1:0] start_addr,
  input  logic [9:0]      Data_len_Polynomial,
  output logic [ADDR-1:0] b_adbus_C,
  output logic            byte_pos_C,
  output logic [ADDR-1:0] b_adbus_D,
  output logic            b_w_A,
  output logic [ADDR-1:0] b_adbus_A,
  output logic            byte_pos_A,
  output logic [2:0]      select_line,
  output logic            cmd_gather,
  output logic            interupt
);

  localparam logic [3:0] CMD_GATHER = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WLO,
    S_WHI,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      k_q, k_d;
  logic [2:0]      wlast_q, wlast_d;
  logic [ADDR-1:0] base_q, base_d;
  logic [ADDR-1:0] addr_c_q, addr_c_d;
  logic [ADDR-1:0] addr_d_q, addr_d_d;
  logic [ADDR-1:0] addr_a_q, addr_a_d;
  logic [ADDR-1:0] src_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      wlast_q  <= '0;
      base_q   <= '0;
      addr_c_q <= '0;
      addr_d_q <= '0;
      addr_a_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wlast_q  <= wlast_d;
      base_q   <= base_d;
      addr_c_q <= addr_c_d;
      addr_d_q <= addr_d_d;
      addr_a_q <= addr_a_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wlast_d  = wlast_q;
    base_d   = base_q;
    addr_c_d = addr_c_q;
    addr_d_d = addr_d_q;
    addr_a_d = addr_a_q;
    src_addr = '0;

    unique case (state_q)
      S_IDLE: begin
        if (command == CMD_GATHER) begin
          state_d = S_RD;
          k_d     = '0;
          // Last word index is len>>7, so the word count is 1..8.
          wlast_d = Data_len_Polynomial[9:7];
          base_d  = start_addr;
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        state_d  = S_WLO;
        addr_a_d = base_q + ADDR'(k_q);
      end
      S_WLO:  state_d = S_WHI;
      S_WHI: begin
        if (k_q == wlast_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
          k_d     = k_q + 3'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Source address is loaded on the edge entering RD; the other bank keeps its value.
    if (state_d == S_RD) begin
      src_addr = base_d + ADDR'(k_d >> 1);
      if (k_d[0]) begin
        addr_d_d = src_addr;
      end else begin
        addr_c_d = src_addr;
      end
    end
  end

  always_comb begin
    b_adbus_C   = addr_c_q;
    b_adbus_D   = addr_d_q;
    b_adbus_A   = addr_a_q;
    b_w_A       = (state_q == S_WLO) || (state_q == S_WHI);
    byte_pos_A  = (state_q == S_WHI);
    byte_pos_C  = (state_q == S_WHI);
    cmd_gather  = (state_q != S_IDLE);
    interupt    = (state_q == S_DONE);
    select_line = 3'h0;
    if ((state_q == S_RD) || (state_q == S_WAIT) || (state_q == S_WLO) || (state_q == S_WHI)) begin
      select_line = k_q[0] ? 3'h5 : 3'h4;
    end
  end

endmodule
